// File: rtl/layer1_pull_pkg.sv
// layer1_rx_pkg: shared constants, packed output word type and keep helper for layer1_pull.
// Ports: none.
package layer1_rx_pkg;
    localparam int LANES = 8;
    localparam int DW = 16;
    localparam int BW = 2 * LANES;
    localparam int BEATS = 64 / BW;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } word_t;
    // Byte enables for a word holding nb beats, lowest bytes first.
    function automatic logic [7:0] keep_of(input logic [CW:0] nb);
        logic [7:0] k;
        for (int b = 0; b < 8; b++) k[b] = (b * 8) < (int'(nb) * BW);
        return k;
    endfunction
endpackage

// File: rtl/layer1_pull_if.sv
// layer1_pull_if: lane I/Q input streams and packed 64-bit output stream.
// Ports: none; master drives the lane streams and consumes the output, slave is the packer.
interface layer1_pull_if;
    import layer1_rx_pkg::*;
    logic [LANES-1:0]         s_axis_inputI_tvalid;
    logic [LANES-1:0]         s_axis_inputI_tready;
    logic [LANES-1:0][DW-1:0] s_axis_inputI_tdata;
    logic [LANES-1:0]         s_axis_inputI_tlast;
    logic [LANES-1:0]         s_axis_inputQ_tvalid;
    logic [LANES-1:0]         s_axis_inputQ_tready;
    logic [LANES-1:0][DW-1:0] s_axis_inputQ_tdata;
    logic [LANES-1:0]         s_axis_inputQ_tlast;
    logic                     m_axis_output_tvalid;
    logic                     m_axis_output_tready;
    logic [63:0]              m_axis_output_tdata;
    logic [7:0]               m_axis_output_tkeep;
    logic                     m_axis_output_tlast;
    modport master (
        output s_axis_inputI_tvalid, s_axis_inputI_tdata, s_axis_inputI_tlast,
        output s_axis_inputQ_tvalid, s_axis_inputQ_tdata, s_axis_inputQ_tlast,
        input  s_axis_inputI_tready, s_axis_inputQ_tready,
        input  m_axis_output_tvalid, m_axis_output_tdata, m_axis_output_tkeep, m_axis_output_tlast,
        output m_axis_output_tready
    );
    modport slave (
        input  s_axis_inputI_tvalid, s_axis_inputI_tdata, s_axis_inputI_tlast,
        input  s_axis_inputQ_tvalid, s_axis_inputQ_tdata, s_axis_inputQ_tlast,
        output s_axis_inputI_tready, s_axis_inputQ_tready,
        output m_axis_output_tvalid, m_axis_output_tdata, m_axis_output_tkeep, m_axis_output_tlast,
        input  m_axis_output_tready
    );
endinterface

// File: rtl/layer1_pull_fifo2.sv
// layer1_pull_fifo2: 2-entry registered AXI-Stream FIFO of packed words.
// Ports: clk, reset (sync, active-high); push_i/din_i write side; space_o = fewer than 2 held;
// valid_o/ready_i/dout_o read side.
module layer1_pull_fifo2
    import layer1_rx_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  push_i,
    input  word_t din_i,
    output logic  space_o,
    output logic  valid_o,
    input  logic  ready_i,
    output word_t dout_o
);
    logic [1:0] cnt_q, cnt_d, wr_idx;
    word_t      head_q, head_d, tail_q, tail_d;
    logic       push, pop;
    assign space_o = cnt_q < 2'd2;
    assign valid_o = cnt_q != 2'd0;
    assign dout_o  = head_q;
    // Space is judged on the registered count only, so a full FIFO never pops through.
    always_comb begin
        push   = push_i & space_o;
        pop    = valid_o & ready_i;
        wr_idx = cnt_q - {1'b0, pop};
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        head_d = (push && wr_idx == 2'd0) ? din_i : pop ? tail_q : head_q;
        tail_d = (push && wr_idx == 2'd1) ? din_i : tail_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
endmodule

// File: rtl/layer1_pull.sv
// layer1_pull: QPSK hard decision on LANES I/Q streams, packed into 64-bit AXI-Stream words.
// Ports: clk, reset (sync, active-high); bus (lane inputs, packed output);
// err_tlast_mismatch sticky lane tlast disagreement; words_out output handshake count.
module layer1_pull
    import layer1_rx_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    layer1_pull_if.slave bus,
    output logic         err_tlast_mismatch,
    output logic [31:0]  words_out
);
    logic          all_valid, space, accept, frame_last, mismatch, done, m_valid;
    logic [BW-1:0] beat;
    logic [63:0]   acc_q, acc_d, cur;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   words_q, words_d;
    word_t         word_in, word_out;
    always_comb begin
        all_valid  = &bus.s_axis_inputI_tvalid & &bus.s_axis_inputQ_tvalid;
        accept     = all_valid & space;
        frame_last = bus.s_axis_inputI_tlast[0];
        mismatch   = accept & ((bus.s_axis_inputI_tlast != {LANES{frame_last}}) |
                               (bus.s_axis_inputQ_tlast != {LANES{frame_last}}));
        beat = '0;
        for (int k = 0; k < LANES; k++) begin
            beat[2*k]   = bus.s_axis_inputI_tdata[k][DW-1];
            beat[2*k+1] = bus.s_axis_inputQ_tdata[k][DW-1];
        end
        // Current beat merged into the accumulator, so a word can be pushed on its last beat.
        cur     = acc_q | (64'(beat) << (BW * int'(cnt_q)));
        done    = accept & ((cnt_q == CW'(BEATS - 1)) | frame_last);
        word_in = '{data: cur, keep: keep_of({1'b0, cnt_q} + 1'b1), last: frame_last};
        cnt_d   = done ? '0 : accept ? cnt_q + 1'b1 : cnt_q;
        acc_d   = done ? '0 : accept ? cur : acc_q;
        err_d   = err_q | mismatch;
        words_d = words_q + 32'(m_valid & bus.m_axis_output_tready);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            words_q <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            words_q <= words_d;
        end
    end
    layer1_pull_fifo2 u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (done),
        .din_i   (word_in),
        .space_o (space),
        .valid_o (m_valid),
        .ready_i (bus.m_axis_output_tready),
        .dout_o  (word_out)
    );
    assign bus.s_axis_inputI_tready = {LANES{accept}};
    assign bus.s_axis_inputQ_tready = {LANES{accept}};
    assign bus.m_axis_output_tvalid = m_valid;
    assign bus.m_axis_output_tdata  = word_out.data;
    assign bus.m_axis_output_tkeep  = word_out.keep;
    assign bus.m_axis_output_tlast  = word_out.last;
    assign err_tlast_mismatch       = err_q;
    assign words_out                = words_q;
endmodule

// File: doc/layer1_pull.md
Name: layer1_pull

Overview:
Receive-side counterpart of the layer1 transmit path. It accepts eight lanes of aligned 16-bit I/Q symbol streams, such as equaliser or loopback outputs. It makes a QPSK hard decision on each lane and packs the resulting bits into a 64-bit AXI-Stream word. Frame boundaries (tlast) are preserved, and partial words are flushed with tkeep. The output feeds the 64-bit DMA/user-data stream.

Parameters:
LANES, 8, number of parallel I/Q lanes; 2 bits per lane per beat; must divide 32.
DW, 16, I/Q sample width (two's complement).
BEATS, 64/(2*LANES)=4, localparam: lane-beats per output word.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
s_axis_inputI_tvalid[LANES]  in  1 each  I lane valid.
s_axis_inputI_tready[LANES]  out  1 each  I lane ready.
s_axis_inputI_tdata[LANES]  in  DW each  I sample.
s_axis_inputI_tlast[LANES]  in  1 each  I end-of-frame.
s_axis_inputQ_tvalid/tready/tdata/tlast[LANES]  in/out/in/in  1/1/DW/1 each  Q lane, same semantics.
m_axis_output_tvalid  out  1  output word valid.
m_axis_output_tready  in  1  downstream ready.
m_axis_output_tdata  out  64  packed decision bits.
m_axis_output_tkeep  out  8  byte enables; 2 bytes per beat at LANES=8.
m_axis_output_tlast  out  1  last word of frame.
err_tlast_mismatch  out  1  sticky: tlast disagreed across lanes on an accepted beat.
words_out  out  32  count of output words transferred; wraps at 2^32.

Behaviour:
- Reset values: all s_axis tready=0, m_axis_output_tvalid=0, tdata=0, tkeep=0, tlast=0, err_tlast_mismatch=0, words_out=0. The packer beat counter is 0, the accumulator is 0, and the FIFO is empty.
- Reset asserted mid-frame or mid-word discards the partial accumulator and all FIFO contents; nothing is flushed.
- all_valid = AND of all 2*LANES tvalids.
- space = output FIFO count < 2.
- Every I and Q tready = all_valid & space, identical on all lanes, so a beat is consumed on all 16 streams in the same cycle or on none. A lane presenting valid alone is never acknowledged.
- Decision per lane k: bit[2k] = I[k][DW-1] (1 = negative), bit[2k+1] = Q[k][DW-1]. This gives a 2*LANES-bit beat vector.
- Packing: beat n of a word (n = 0..BEATS-1) occupies tdata[16n+15:16n]. The beat counter increments per accepted beat.
- Word complete when the counter reaches BEATS-1, or the accepted beat has frame_last=1.
  - The word is written into the FIFO in that same cycle, assembled from the accumulator plus the current beat.
  - The counter returns to 0 and the accumulator clears.
  - Unfilled beats read as 0. tkeep has 2 bits set per filled beat, LSB first (e.g. 2 beats gives 8'h0F). tlast = frame_last.
- frame_last = I lane 0 tlast.
  - If any of the 2*LANES tlasts differs from frame_last on an accepted beat, err_tlast_mismatch is set and stays set until reset.
  - Data still follows frame_last.
- Latency: the word is visible on m_axis the cycle after its last beat is accepted when the FIFO was empty.
- Throughput: one beat per cycle sustained while downstream is ready.
- Output FIFO: 2 entries, registered.
  - Pop on m_axis_output_tvalid & tready. Data, tkeep and tlast are held stable while tvalid=1 and tready=0.
  - Simultaneous push and pop leaves the count unchanged.
  - At count=2, space=0, so no beats are accepted until a pop is registered. Pop-through is not permitted.
- words_out increments on each output handshake.

Decomposition:
- Package layer1_rx_pkg: LANES, DW, the BEATS derivation, and a typedef for the packed word struct {data[63:0], keep[7:0], last}.
- One sub-module, layer1_pull_fifo2: 2-entry AXI-Stream register FIFO carrying that struct. The packer and decision logic stay in the top level.

Test Plan:
- Single full word, downstream always ready: 4 beats with all I=16'h8000, Q=16'h0001 -> one word tdata=64'h5555_5555_5555_5555, tkeep=8'hFF, tlast=0, one cycle after the 4th beat.
- Frame end on beat 2 of a word: I=Q=16'hFFFF, tlast on beat index 1 -> tdata=64'h0000_0000_FFFF_FFFF, tkeep=8'h0F, tlast=1. The next beat starts a fresh word at bit 0.
- Lane misalignment: lane 5 Q valid held low for 3 cycles while the others are valid -> all tready=0 for those cycles and no beat consumed. After release, one beat is consumed on all lanes simultaneously.
- Backpressure: m_axis_output_tready=0 during 12 beats -> exactly 8 beats (2 words) accepted, then tready=0 on all lanes. Output data stays stable. Releasing tready delivers the words in order, and words_out=2 after both transfers.
- tlast mismatch: lane 3 I tlast=1 while lane 0 I tlast=0 -> err_tlast_mismatch=1 sticky and the word is not terminated. Reset clears the flag to 0.
- Reset mid-word: 2 beats accepted, then reset for 1 cycle -> no output word. The next 4 beats produce a single clean word with tkeep=8'hFF.
